tty_kbd_in: RTL

//  TTY input path, the receive side of the text terminal. The VGA TTY block displays CPU writes; this block feeds the CPU.
//  - Receives PS/2 keyboard frames and decodes set-2 scancodes to ASCII.
//  - Queues the characters in a small FIFO.
//  - Returns one character per CPU read strobe, using the same level-strobe edge-flag handshake as the TTY write path.

---
 rtl/tty_kbd_in_pkg.sv | 55 +++++
 rtl/tty_kbd_in_ps2_rx_frame.sv | 120 ++++++++++++
 rtl/tty_kbd_in.sv | 118 +++++++++++
 3 files changed

// File: rtl/tty_kbd_in_pkg.sv
// Shared scancode constants, receiver state type and the set-2 to ASCII lookup
// used by the keyboard input path.
package tty_kbd_in_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_BS  = 8'h08;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Unknown codes map to 0x00, which the caller treats as "nothing to push".
    function automatic logic [7:0] sc2ascii(input logic [7:0] sc, input logic shift);
        logic [15:0] pair;
        pair = 16'h0000;
        case (sc)
            8'h1C: pair = {"a", "A"};  8'h32: pair = {"b", "B"};
            8'h21: pair = {"c", "C"};  8'h23: pair = {"d", "D"};
            8'h24: pair = {"e", "E"};  8'h2B: pair = {"f", "F"};
            8'h34: pair = {"g", "G"};  8'h33: pair = {"h", "H"};
            8'h43: pair = {"i", "I"};  8'h3B: pair = {"j", "J"};
            8'h42: pair = {"k", "K"};  8'h4B: pair = {"l", "L"};
            8'h3A: pair = {"m", "M"};  8'h31: pair = {"n", "N"};
            8'h44: pair = {"o", "O"};  8'h4D: pair = {"p", "P"};
            8'h15: pair = {"q", "Q"};  8'h2D: pair = {"r", "R"};
            8'h1B: pair = {"s", "S"};  8'h2C: pair = {"t", "T"};
            8'h3C: pair = {"u", "U"};  8'h2A: pair = {"v", "V"};
            8'h1D: pair = {"w", "W"};  8'h22: pair = {"x", "X"};
            8'h35: pair = {"y", "Y"};  8'h1A: pair = {"z", "Z"};
            8'h45: pair = {"0", ")"};  8'h16: pair = {"1", "!"};
            8'h1E: pair = {"2", "@"};  8'h26: pair = {"3", "#"};
            8'h25: pair = {"4", "$"};  8'h2E: pair = {"5", "%"};
            8'h36: pair = {"6", "^"};  8'h3D: pair = {"7", "&"};
            8'h3E: pair = {"8", "*"};  8'h46: pair = {"9", "("};
            8'h29: pair = {" ", " "};  8'h0E: pair = {8'h60, "~"};
            8'h4E: pair = {"-", "_"};  8'h55: pair = {"=", "+"};
            8'h54: pair = {"[", "{"};  8'h5B: pair = {"]", "}"};
            8'h5D: pair = {"\\", "|"}; 8'h4C: pair = {";", ":"};
            8'h52: pair = {"'", "\""}; 8'h41: pair = {",", "<"};
            8'h49: pair = {".", ">"};  8'h4A: pair = {"/", "?"};
            default: pair = 16'h0000;
        endcase
        return shift ? pair[7:0] : pair[15:8];
    endfunction

endpackage

// File: rtl/tty_kbd_in_ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the raw lines, debounces the keyboard
// clock, and assembles start/8 data/odd parity/stop frames into bytes.
module tty_kbd_in_ps2_rx_frame
    import tty_kbd_in_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FW-1:0] flt_cnt;
    logic          clk_f;
    logic          flt_flip;
    logic          fall;

    rx_state_t     state, state_nx;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          frame_ok;

    // Two-flop synchronisers; lines idle high.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            {clk_s1, clk_s2, dat_s1, dat_s2} <= 4'b1111;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign flt_flip = (clk_s2 != clk_f) && (flt_cnt == FW'(FILTER_LEN - 1));
    assign fall     = flt_flip && clk_f;

    // Filtered clock only follows the raw level after FILTER_LEN differing samples.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            clk_f   <= 1'b1;
            flt_cnt <= '0;
        end else if (clk_s2 == clk_f) begin
            flt_cnt <= '0;
        end else if (flt_flip) begin
            clk_f   <= clk_s2;
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    assign timeout = (state != RX_IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));

    // Frame state register.
    always_ff @(posedge clk_50mhz) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_nx;
    end

    // Next state and frame acceptance; a fall always beats a timeout.
    always_comb begin
        state_nx = state;
        frame_ok = 1'b0;
        if (fall) begin
            case (state)
                RX_IDLE:   if (!dat_s2) state_nx = RX_DATA;
                RX_DATA:   if (bitcnt == 3'd7) state_nx = RX_PARITY;
                RX_PARITY: state_nx = RX_STOP;
                RX_STOP: begin
                    state_nx = RX_IDLE;
                    frame_ok = dat_s2 && (^{shreg, par_bit});
                end
                default:   state_nx = RX_IDLE;
            endcase
        end else if (timeout) begin
            state_nx = RX_IDLE;
        end
    end

    // Shift register, bit counter, idle timer and the byte strobe.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            bitcnt   <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            to_cnt   <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= frame_ok;
            if (frame_ok) rx_byte <= shreg;
            if (state == RX_IDLE || fall) to_cnt <= '0;
            else                          to_cnt <= to_cnt + 1'b1;
            if (fall) begin
                case (state)
                    RX_IDLE:   bitcnt <= '0;
                    RX_DATA: begin
                        shreg[bitcnt] <= dat_s2;
                        bitcnt        <= bitcnt + 1'b1;
                    end
                    RX_PARITY: par_bit <= dat_s2;
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: rtl/tty_kbd_in.sv
// TTY keyboard input: scancode decoder, character FIFO and the CPU read
// handshake (one pop per rising edge of Memread).
module tty_kbd_in
    import tty_kbd_in_pkg::*;
#(
    parameter int FIFO_AW     = 4,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        Memread,
    output logic [31:0] kbd_data,
    output logic        kbd_ready,
    output logic        kbd_ovf
);

    logic [7:0]     rx_byte;
    logic           rx_valid;
    logic           shift_f, brk_f, ext_f;
    logic           push_en;
    logic [7:0]     push_char;
    logic [7:0]     lut_char;
    logic           is_shift;

    logic [7:0]     mem [2**FIFO_AW];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, wr_nx, rd_nx;
    logic           empty, full, pop, push_ok, rdflag;

    tty_kbd_in_ps2_rx_frame #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk_50mhz(clk_50mhz),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid)
    );

    assign lut_char = sc2ascii(rx_byte, shift_f);
    assign is_shift = (rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT);

    // Decoder: track prefix/shift flags and register one char push per make code.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            shift_f   <= 1'b0;
            brk_f     <= 1'b0;
            ext_f     <= 1'b0;
            push_en   <= 1'b0;
            push_char <= '0;
        end else begin
            push_en <= 1'b0;
            if (rx_valid) begin
                if (rx_byte == SC_EXT) begin
                    ext_f <= 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    brk_f <= 1'b1;
                end else if (brk_f) begin
                    if (is_shift) shift_f <= 1'b0;
                    brk_f <= 1'b0;
                    ext_f <= 1'b0;
                end else if (ext_f) begin
                    ext_f <= 1'b0;
                end else if (is_shift) begin
                    shift_f <= 1'b1;
                end else if (rx_byte == SC_ENTER) begin
                    push_en   <= 1'b1;
                    push_char <= ASCII_CR;
                end else if (rx_byte == SC_BKSP) begin
                    push_en   <= 1'b1;
                    push_char <= ASCII_BS;
                end else if (lut_char != 8'h00) begin
                    push_en   <= 1'b1;
                    push_char <= lut_char;
                end
            end
        end
    end

    // Handshake: pop only on a fresh Memread edge with data waiting. A pop in
    // the same cycle frees the slot a full-FIFO push needs.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop     = Memread && !rdflag && !empty;
    assign push_ok = push_en && (!full || pop);
    assign wr_nx   = wr_ptr + (FIFO_AW + 1)'(push_ok);
    assign rd_nx   = rd_ptr + (FIFO_AW + 1)'(pop);

    // FIFO storage.
    always_ff @(posedge clk_50mhz) begin
        if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= push_char;
    end

    // Pointers, read data, ready/overflow flags and the Memread edge tracker.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            kbd_data  <= '0;
            kbd_ready <= 1'b0;
            kbd_ovf   <= 1'b0;
            rdflag    <= 1'b0;
        end else begin
            wr_ptr    <= wr_nx;
            rd_ptr    <= rd_nx;
            kbd_ready <= (wr_nx != rd_nx);
            rdflag    <= Memread;
            if (pop) kbd_data <= {24'h0, mem[rd_ptr[FIFO_AW-1:0]]};
            if (push_en && full && !pop) kbd_ovf <= 1'b1;
        end
    end

endmodule
